// File: rtl/ram16x16_write_module.sv
// ram16x16_write_module
//   Producer side of the 16x16 monochrome bitmap RAM scanned by the VGA path.
//   Collects ROWS row words over a valid/ready handshake into a staging buffer,
//   then commits the whole buffer to the RAM write port in one burst started by
//   the next frame pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   frame_sig  1-cycle pulse per frame (start of vertical blanking)
//   clear      discard a partially filled / waiting buffer
//   in_data    row word, rows arrive in order 0..ROWS-1
//   in_valid   in_data valid
//   in_ready   writer can accept in_data this cycle
//   ram_we     RAM write enable (registered)
//   ram_waddr  RAM row address (registered, holds when idle)
//   ram_wdata  RAM row data (registered, holds when idle)
//   busy       high while waiting for a frame or writing
//   done       1-cycle pulse after the last row is written
//
// Configuration macro
//   RAM16_WRITER_TESTPAT_EN : buffer resets to a diagonal test pattern and the
//   block comes out of reset waiting for a frame, so the first frame_sig paints
//   the pattern before any upstream data is loaded.

module ram16x16_write_module #(
   parameter int DATA_W = 16,
   parameter int ROWS   = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_sig,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);

`ifdef RAM16_WRITER_TESTPAT_EN
   localparam state_t RST_STATE = S_WAIT;
`else
   localparam state_t RST_STATE = S_FILL;
`endif

   state_t                       state, state_nxt;
   logic [ADDR_W-1:0]            idx;      // next buffer slot to fill
   logic [ADDR_W-1:0]            row;      // row currently on the RAM port
   logic [ROWS-1:0][DATA_W-1:0]  row_buf;
   logic                         accept;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST_STATE;
      else        state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // Next state and decoded outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         S_FILL: begin
            in_ready = 1'b1;
            // clear beats a same-cycle word: the word is dropped
            accept   = in_valid && !clear;
            if (accept && idx == LAST) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (clear)          state_nxt = S_FILL;
            else if (frame_sig) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy = 1'b1;
            if (row == LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_FILL;
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: staging buffer, fill index, RAM write port
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         row       <= '0;
         ram_we    <= 1'b0;
         ram_waddr <= '0;
         ram_wdata <= '0;
         for (int r = 0; r < ROWS; r++) begin
`ifdef RAM16_WRITER_TESTPAT_EN
            row_buf[r] <= DATA_W'(1) << (DATA_W - 1 - r);
`else
            row_buf[r] <= '0;
`endif
         end
      end else begin
         case (state)
            S_FILL: begin
               if (clear) begin
                  idx <= '0;
               end else if (accept) begin
                  row_buf[idx] <= in_data;
                  idx          <= (idx == LAST) ? '0 : idx + 1'b1;
               end
            end
            S_WAIT: begin
               if (clear) begin
                  idx <= '0;
               end else if (frame_sig) begin
                  // Row 0 is issued on the frame edge itself so the first
                  // RAM write lands one cycle after frame_sig.
                  row       <= '0;
                  ram_we    <= 1'b1;
                  ram_waddr <= '0;
                  ram_wdata <= row_buf[0];
               end
            end
            S_WRITE: begin
               if (row == LAST) begin
                  ram_we <= 1'b0;
               end else begin
                  row       <= row + 1'b1;
                  ram_waddr <= row + 1'b1;
                  ram_wdata <= row_buf[row + 1'b1];
               end
            end
            S_DONE: begin
               idx    <= '0;
               ram_we <= 1'b0;
            end
            default: ram_we <= 1'b0;
         endcase
      end
   end

endmodule
